// File: rtl/mem_access_unit.sv
// Memory-stage access unit: turns M-stage load/store controls into a registered
// data-memory request, stalls the pipeline until the access completes or times out,
// and owns the M/W pipeline register.
//
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   RegWriteM, MemWriteM, ResultSrcM, ALUResultM, WriteDataM, RdM, PCPlus4M
//                         M-stage instruction fields (ResultSrcM=2'b01 is a load)
//   memReq, memWe, memAddr, memWData
//                         registered data-memory request
//   memAck, memRData      memory completion strobe and load data
//   StallM                holds F/D/E/M registers while high
//   RegWriteW, ResultSrcW, ALUResultW, ReadDataW, RdW, PCPlus4W
//                         M/W pipeline register
//   errMisalign, errTimeout
//                         sticky error flags, cleared only by reset
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  RdM,
  input  logic [31:0] PCPlus4M,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWData,
  input  logic        memAck,
  input  logic [31:0] memRData,
  output logic        StallM,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [4:0]  RdW,
  output logic [31:0] PCPlus4W,
  output logic        errMisalign,
  output logic        errTimeout
);

  localparam int unsigned CntW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StResp = 2'd2
  } state_e;

  state_e          state;
  logic [CntW-1:0] tmo_cnt;
  logic [CntW-1:0] tmo_cnt_inc;
  logic [31:0]     rdata_buf;
  logic            mem_op;
  logic            aligned;
  logic            start;
  logic            misalign;

  always_comb begin
    mem_op      = MemWriteM | (ResultSrcM == 2'b01);
    aligned     = (ALUResultM[1:0] == 2'b00);
    start       = mem_op & aligned;
    misalign    = mem_op & ~aligned;
    tmo_cnt_inc = tmo_cnt + CntW'(1);
  end

  // Combinational so the instruction is held in M on the very cycle it is detected.
  // Gated by rst so the pipeline is released while reset is asserted.
  assign StallM = rst & (((state == StIdle) & start) | (state == StBusy));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= StIdle;
      memReq      <= 1'b0;
      memWe       <= 1'b0;
      memAddr     <= 32'h0;
      memWData    <= 32'h0;
      tmo_cnt     <= '0;
      rdata_buf   <= 32'h0;
      errMisalign <= 1'b0;
      errTimeout  <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (start) begin
            memReq   <= 1'b1;
            memWe    <= MemWriteM;
            memAddr  <= ALUResultM;
            memWData <= WriteDataM;
            tmo_cnt  <= '0;
            state    <= StBusy;
          end else if (misalign) begin
            errMisalign <= 1'b1;
          end
        end
        StBusy: begin
          // Ack has priority over the timeout in the same cycle.
          if (memAck) begin
            rdata_buf <= memWe ? 32'h0 : memRData;
            memReq    <= 1'b0;
            memWe     <= 1'b0;
            state     <= StResp;
          end else if (tmo_cnt_inc == CntW'(TIMEOUT)) begin
            errTimeout <= 1'b1;
            rdata_buf  <= 32'h0;
            memReq     <= 1'b0;
            memWe      <= 1'b0;
            state      <= StResp;
          end else begin
            tmo_cnt <= tmo_cnt_inc;
          end
        end
        StResp: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

  // M/W register: bubble while stalled (data fields hold), otherwise capture M.
  // ReadDataW carries the access result only on the RESP pass-through.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
      ALUResultW <= 32'h0;
      ReadDataW  <= 32'h0;
      RdW        <= 5'd0;
      PCPlus4W   <= 32'h0;
    end else if (StallM) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
      RdW        <= 5'd0;
    end else begin
      RegWriteW  <= RegWriteM;
      ResultSrcW <= ResultSrcM;
      ALUResultW <= ALUResultM;
      ReadDataW  <= (state == StResp) ? rdata_buf : 32'h0;
      RdW        <= RdM;
      PCPlus4W   <= PCPlus4M;
    end
  end

endmodule
